// File: rtl/peri_pkg.sv
// Shared constants and state encoding for the peripheral result-return path.
package peri_pkg;

  localparam int unsigned PERI_SAMPLE_W  = 8;
  localparam int unsigned PERI_OUT_DEPTH = 32;
  localparam int unsigned PERI_LANES     = 32 / PERI_SAMPLE_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } out_state_e;

endpackage

// File: rtl/peri_out_mem.sv
// DEPTH x 32 result storage: one synchronous write port, one synchronous read port.
// The storage is deliberately unreset; the owner masks reads beyond the committed count.
module peri_out_mem #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic             i_re,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/peri_out_buf.sv
// Packs ADC samples into 32-bit words of a result buffer and serves
// random-access reads of the committed words back to the controller.
module peri_out_buf
  import peri_pkg::*;
#(
  parameter int unsigned SAMPLE_W = PERI_SAMPLE_W,
  parameter int unsigned DEPTH    = PERI_OUT_DEPTH,
  parameter int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                sample_valid_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                frame_end_i,
  input  logic                out_buf_read_i,
  input  logic [PTR_W-1:0]    read_ptr_i,
  output logic [31:0]         out_buf_data_o,
  output logic                out_buf_rvalid_o,
  output logic [PTR_W:0]      word_cnt_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overflow_o
);

  localparam int unsigned LANES  = 32 / SAMPLE_W;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  out_state_e        r_state;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [LANE_W-1:0] r_lane_cnt;
  logic [31:0]       r_pack;
  logic              r_overflow;
  logic              r_busy;
  logic              r_done;
  logic              r_rvalid;
  logic              r_rd_hit;

  out_state_e        w_state_nxt;
  logic [CNT_W-1:0]  w_word_cnt_nxt;
  logic [LANE_W-1:0] w_lane_nxt;
  logic [31:0]       w_pack_nxt;
  logic              w_ovf_nxt;
  logic              w_full;
  logic [31:0]       w_lane_data;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wr_addr;
  logic [31:0]       w_wr_data;
  logic [31:0]       w_mem_rdata;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  assign w_full = (r_word_cnt == CNT_W'(DEPTH));

  // Pack register with the incoming sample dropped into the current lane.
  always_comb begin
    w_lane_data = r_pack;
    for (int k = 0; k < int'(LANES); k++) begin
      if (r_lane_cnt == LANE_W'(k)) begin
        w_lane_data[k*SAMPLE_W +: SAMPLE_W] = sample_i;
      end
    end
  end

  // Next-state, packing and buffer-write decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_lane_nxt     = r_lane_cnt;
    w_pack_nxt     = r_pack;
    w_ovf_nxt      = r_overflow;
    w_wr_en        = 1'b0;
    w_wr_addr      = r_word_cnt[PTR_W-1:0];
    w_wr_data      = r_pack;

    if (start_i) begin
      w_state_nxt    = COLLECT;
      w_word_cnt_nxt = '0;
      w_lane_nxt     = '0;
      w_pack_nxt     = '0;
      w_ovf_nxt      = 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (sample_valid_i) begin
            if (w_full) begin
              w_ovf_nxt = 1'b1;
            end else if (r_lane_cnt == LANE_W'(LANES - 1)) begin
              w_wr_en        = 1'b1;
              w_wr_data      = w_lane_data;
              w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
              w_lane_nxt     = '0;
              w_pack_nxt     = '0;
            end else begin
              w_lane_nxt = r_lane_cnt + LANE_W'(1);
              w_pack_nxt = w_lane_data;
            end
          end
          if (frame_end_i) begin
            w_state_nxt = FLUSH;
          end
        end
        FLUSH: begin
          // Unused upper lanes of a partial word are already zero in the pack register.
          if (r_lane_cnt != '0) begin
            if (w_full) begin
              w_ovf_nxt = 1'b1;
            end else begin
              w_wr_en        = 1'b1;
              w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
            end
          end
          w_lane_nxt  = '0;
          w_pack_nxt  = '0;
          w_state_nxt = DONE;
        end
        default: begin
        end
      endcase
    end
  end

  assign w_busy_nxt = (w_state_nxt == COLLECT) || (w_state_nxt == FLUSH);
  assign w_done_nxt = (w_state_nxt == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_word_cnt <= '0;
      r_lane_cnt <= '0;
      r_pack     <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_lane_cnt <= w_lane_nxt;
      r_pack     <= w_pack_nxt;
      r_overflow <= w_ovf_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Hit flag is captured against the count at request time, so a word still being written reads as 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rd_hit <= 1'b0;
    end else begin
      r_rvalid <= out_buf_read_i;
      if (out_buf_read_i) begin
        r_rd_hit <= ({1'b0, read_ptr_i} < r_word_cnt);
      end
    end
  end

  peri_out_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .i_we    (w_wr_en),
    .i_waddr (w_wr_addr),
    .i_wdata (w_wr_data),
    .i_re    (out_buf_read_i),
    .i_raddr (read_ptr_i),
    .o_rdata (w_mem_rdata)
  );

  assign out_buf_data_o   = r_rd_hit ? w_mem_rdata : 32'h0;
  assign out_buf_rvalid_o = r_rvalid;
  assign word_cnt_o       = r_word_cnt;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign overflow_o       = r_overflow;

endmodule

// File: tb/tb_peri_out_buf.sv
// Scoreboard bench for peri_out_buf: reads push expected words, a monitor pops on rvalid.
module tb_peri_out_buf;

  localparam int unsigned SW    = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned PTR_W = 5;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sample_valid;
  logic [SW-1:0]    sample;
  logic             frame_end;
  logic             rd;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      rd_data;
  logic             rvalid;
  logic [PTR_W:0]   word_cnt;
  logic             busy;
  logic             done;
  logic             overflow;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  peri_out_buf dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .sample_valid_i   (sample_valid),
    .sample_i         (sample),
    .frame_end_i      (frame_end),
    .out_buf_read_i   (rd),
    .read_ptr_i       (rd_ptr),
    .out_buf_data_o   (rd_data),
    .out_buf_rvalid_o (rvalid),
    .word_cnt_o       (word_cnt),
    .busy_o           (busy),
    .done_o           (done),
    .overflow_o       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check_eq(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every rvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      if (exp_q.size() == 0) begin
        check_eq("rvalid_unexpected", 32'h1, 32'h0);
      end else begin
        check_eq("read_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] s);
    sample_valid = 1'b1;
    sample       = s;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    step();
  endtask

  task automatic do_read(input logic [PTR_W-1:0] p, input logic [31:0] exp);
    rd     = 1'b1;
    rd_ptr = p;
    exp_q.push_back(exp);
    step();
    rd = 1'b0;
  endtask

  task automatic check_status(string tag, input int wc, input logic b, input logic d, input logic o);
    check_eq({tag, "_word_cnt"}, 32'(word_cnt), 32'(wc));
    check_eq({tag, "_busy"}, 32'(busy), 32'(b));
    check_eq({tag, "_done"}, 32'(done), 32'(d));
    check_eq({tag, "_overflow"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    frame_end = 1'b0;
    rd = 1'b0;
    rd_ptr = '0;

    #12;
    check_status("reset", 0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_read(5'd0, 32'h0);
    step();
    check_status("idle", 0, 1'b0, 1'b0, 1'b0);

    // Basic frame with a partial final word.
    pulse_start();
    check_status("started", 0, 1'b1, 1'b0, 1'b0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    end_frame();
    check_status("frame1", 2, 1'b0, 1'b1, 1'b0);
    do_read(5'd0, 32'h44332211);
    do_read(5'd1, 32'h00000055);
    do_read(5'd2, 32'h0);
    do_read(5'd31, 32'h0);
    step();
    check_eq("rdata_hold", rd_data, 32'h0);

    // Fill the buffer, then one extra sample overflows.
    pulse_start();
    for (int i = 0; i < 4 * int'(DEPTH); i++) send(SW'(i));
    check_status("full", 32, 1'b1, 1'b0, 1'b0);
    send(8'hAA);
    check_eq("ovf_set", 32'(overflow), 32'h1);
    end_frame();
    check_status("frame_full", 32, 1'b0, 1'b1, 1'b1);
    do_read(5'd31, 32'h7F7E7D7C);
    do_read(5'd0, 32'h03020100);
    do_read(5'd17, 32'h47464544);

    // Abort mid-frame.
    pulse_start();
    for (int i = 0; i < 6; i++) send(8'hE0 + SW'(i));
    check_eq("pre_abort_cnt", 32'(word_cnt), 32'd1);
    pulse_start();
    check_status("abort", 0, 1'b1, 1'b0, 1'b0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check_eq("abort_cnt", 32'(word_cnt), 32'd1);
    end_frame();
    check_status("frame_abort", 1, 1'b0, 1'b1, 1'b0);
    do_read(5'd0, 32'h04030201);
    do_read(5'd1, 32'h0);

    // Sample coincident with frame_end is packed before the flush.
    pulse_start();
    send(8'h01); send(8'h02);
    sample_valid = 1'b1;
    sample = 8'h99;
    end_frame();
    sample_valid = 1'b0;
    check_status("coinc", 1, 1'b0, 1'b1, 1'b0);
    do_read(5'd0, 32'h00990201);

    // start wins over frame_end: no flush, buffer cleared.
    pulse_start();
    send(8'h01); send(8'h02); send(8'h03);
    start = 1'b1;
    frame_end = 1'b1;
    step();
    start = 1'b0;
    frame_end = 1'b0;
    check_status("start_fe", 0, 1'b1, 1'b0, 1'b0);
    step();
    check_status("start_fe2", 0, 1'b1, 1'b0, 1'b0);
    send(8'h05);
    end_frame();
    check_status("start_fe3", 1, 1'b0, 1'b1, 1'b0);
    do_read(5'd0, 32'h00000005);

    // Read of the word being committed in the same cycle returns 0.
    pulse_start();
    send(8'hA1); send(8'hA2); send(8'hA3);
    sample_valid = 1'b1;
    sample = 8'hA4;
    do_read(5'd0, 32'h0);
    sample_valid = 1'b0;
    do_read(5'd0, 32'hA4A3A2A1);

    // Async reset between edges mid-COLLECT.
    send(8'hB1); send(8'hB2); send(8'hB3);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_status("async_rst", 0, 1'b0, 1'b0, 1'b0);
    check_eq("async_rst_data", rd_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_read(5'd0, 32'h0);
    do_read(5'd1, 32'h0);
    step();
    step();
    check_eq("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
